// File: rtl/exec_addx_seq.sv
// Multi-cycle add/subtract unit: operands are consumed LSB-first, one W_SLICE-bit
// slice per cycle, with the carry held in a register between slices.
module exec_addx_seq #(
    parameter int W_OPR   = 32,
    parameter int W_SLICE = 8,
    parameter int W_FLAGS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [W_OPR-1:0]   opr0_i,
    input  logic [W_OPR-1:0]   opr1_i,
    input  logic [1:0]         select_i,
    input  logic [W_FLAGS-1:0] flags_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [W_OPR-1:0]   result_o,
    output logic [W_FLAGS-1:0] flags_o
);
    // Handshake: a request transfers on a rising edge with valid_i & ready_o, a
    // result on a rising edge with valid_o & ready_i. ready_o is high only in
    // IDLE and valid_o only in DONE, so the two never overlap.

    localparam int N_SLICE = W_OPR / W_SLICE;
    localparam int CNT_W   = (N_SLICE > 1) ? $clog2(N_SLICE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_SLICE - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t state_q, state_d;

    logic [W_OPR-1:0]   a_q, b_q, res_q;
    logic               a_msb_q, b_msb_q, sub_q, c_q, zero_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               last_slice;

    logic [W_SLICE:0]         slice_sum;
    logic [W_OPR+W_SLICE-1:0] res_cat;
    logic [W_OPR-1:0]         res_next;
    logic                     zero_next;
    logic [W_FLAGS-1:0]       flags_next;
    logic                     unused_flags;

    assign unused_flags = ^flags_i[W_FLAGS-1:1];
    assign last_slice   = (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (valid_i)    state_d = S_RUN;
            S_RUN:   if (last_slice) state_d = S_DONE;
            S_DONE:  if (ready_i)    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ready_o = (state_q == S_IDLE);
        valid_o = (state_q == S_DONE);
    end

    // a_q/b_q shift right each slice, so the current slice is always the low bits;
    // the result fills from the top and lands in place after N_SLICE shifts.
    always_comb begin
        slice_sum  = {1'b0, a_q[W_SLICE-1:0]} + {1'b0, b_q[W_SLICE-1:0]}
                   + {{W_SLICE{1'b0}}, c_q};
        res_cat    = {slice_sum[W_SLICE-1:0], res_q};
        res_next   = res_cat[W_OPR+W_SLICE-1:W_SLICE];
        zero_next  = zero_q & ~(|slice_sum[W_SLICE-1:0]);
        flags_next = {(a_msb_q == b_msb_q) & (res_next[W_OPR-1] != a_msb_q),
                      res_next[W_OPR-1],
                      zero_next,
                      slice_sum[W_SLICE] ^ sub_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            sub_q    <= 1'b0;
            c_q      <= 1'b0;
            zero_q   <= 1'b0;
            cnt_q    <= '0;
            result_o <= '0;
            flags_o  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (valid_i) begin
                        a_q     <= opr0_i;
                        b_q     <= select_i[0] ? ~opr1_i : opr1_i;
                        a_msb_q <= opr0_i[W_OPR-1];
                        b_msb_q <= select_i[0] ? ~opr1_i[W_OPR-1] : opr1_i[W_OPR-1];
                        sub_q   <= select_i[0];
                        c_q     <= select_i[1] ? (flags_i[0] ^ select_i[0]) : select_i[0];
                        cnt_q   <= '0;
                        zero_q  <= 1'b1;
                    end
                end
                S_RUN: begin
                    a_q    <= a_q >> W_SLICE;
                    b_q    <= b_q >> W_SLICE;
                    res_q  <= res_next;
                    c_q    <= slice_sum[W_SLICE];
                    zero_q <= zero_next;
                    cnt_q  <= cnt_q + 1'b1;
                    if (last_slice) begin
                        result_o <= res_next;
                        flags_o  <= flags_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
